// File: rtl/nettlp_cmd_pkg.sv
// Shared types and constants for the NetTLP command TX path.
package nettlp_cmd_pkg;

  typedef logic [95:0] FIFO_NETTLP_CMD_T;

  localparam logic [15:0] ETHTYPE_IPV4           = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP           = 8'h11;
  localparam int          NETTLP_CMD_FRAME_BEATS = 8;
  localparam logic [15:0] NETTLP_CMD_IP_TOTLEN   = 16'd44;
  localparam logic [15:0] NETTLP_CMD_UDP_LEN     = 16'd24;

  // TX FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CSUM = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

endpackage

// File: rtl/nettlp_ip_csum.sv
// IPv4 header checksum: registered 32-bit sum of nine words, then a combinational fold.
module nettlp_ip_csum
  import nettlp_cmd_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [143:0] words_in,
  output logic [15:0]  csum_out
);

  logic [31:0] sum_d, sum_q;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum_d = 32'h0;
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + {16'h0, words_in[16*i +: 16]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sum_q <= 32'h0;
    else        sum_q <= sum_d;
  end

  // The second fold cannot overflow, since fold1 is at most 0x1FFFE.
  assign fold1    = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
  assign fold2    = fold1[15:0] + {15'h0, fold1[16]};
  assign csum_out = ~fold2;

endmodule

// File: rtl/nettlp_cmd_tx.sv
// Pops command responses and emits each as one 60-byte Ethernet/IPv4/UDP frame in 8 beats.
module nettlp_cmd_tx
  import nettlp_cmd_pkg::*;
#(
  parameter int         ETH_W  = 64,
  parameter logic [7:0] IP_TTL = 8'd64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fifo_cmd_rd_en,
  input  logic                 fifo_cmd_empty,
  input  FIFO_NETTLP_CMD_T     fifo_cmd_dout,
  input  logic [31:0]          adapter_reg_magic,
  input  logic [47:0]          adapter_reg_dstmac,
  input  logic [47:0]          adapter_reg_srcmac,
  input  logic [31:0]          adapter_reg_dstip,
  input  logic [31:0]          adapter_reg_srcip,
  input  logic [15:0]          adapter_reg_dstport,
  input  logic [15:0]          adapter_reg_srcport,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [ETH_W-1:0]     m_axis_tdata,
  output logic [ETH_W/8-1:0]   m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic [31:0]          tx_frames
);

  logic [1:0]       state_d, state_q;
  FIFO_NETTLP_CMD_T cmd_d, cmd_q;
  logic [31:0]      magic_d, magic_q, dstip_d, dstip_q, srcip_d, srcip_q;
  logic [47:0]      dstmac_d, dstmac_q, srcmac_d, srcmac_q;
  logic [15:0]      dstport_d, dstport_q, srcport_d, srcport_q;
  logic [15:0]      ip_id_d, ip_id_q, csum_d, csum_q;
  logic [31:0]      tx_frames_d, tx_frames_q;
  logic [2:0]       beat_cnt_d, beat_cnt_q, beat_sel;
  logic [63:0]      tdata_d, tdata_q;
  logic [7:0]       tkeep_d, tkeep_q;
  logic             tlast_d, tlast_q, tvalid_d, tvalid_q;

  logic [15:0]  csum_w;
  logic [143:0] csum_words;
  logic [511:0] frame_w;
  logic [63:0]  beat_words [8];
  logic [63:0]  beat_be, beat_data;

  assign csum_words = {srcip_q[31:16], srcip_q[15:0], dstip_q[31:16], dstip_q[15:0],
                       IP_TTL, IP_PROTO_UDP, 16'h4000, ip_id_q,
                       NETTLP_CMD_IP_TOTLEN, 16'h4500};

  nettlp_ip_csum u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .words_in (csum_words),
    .csum_out (csum_w)
  );

  // Wire-order frame, first byte in the MSBs; the trailing 6 zero bytes pad beat 7.
  assign frame_w = {dstmac_q, srcmac_q, ETHTYPE_IPV4,
                    16'h4500, NETTLP_CMD_IP_TOTLEN, ip_id_q, 16'h4000, IP_TTL, IP_PROTO_UDP,
                    csum_q, srcip_q, dstip_q,
                    srcport_q, dstport_q, NETTLP_CMD_UDP_LEN, 16'h0000,
                    magic_q, cmd_q, 48'h0};

  generate
    for (genvar gi = 0; gi < NETTLP_CMD_FRAME_BEATS; gi++) begin : g_beat
      assign beat_words[gi] = frame_w[511-64*gi -: 64];
    end
  endgenerate

  assign beat_sel = (state_q == ST_SEND) ? beat_cnt_q + 3'd1 : 3'd0;
  assign beat_be  = beat_words[beat_sel];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_swap
      assign beat_data[8*gi +: 8] = beat_be[63-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    magic_d        = magic_q;
    dstmac_d       = dstmac_q;
    srcmac_d       = srcmac_q;
    dstip_d        = dstip_q;
    srcip_d        = srcip_q;
    dstport_d      = dstport_q;
    srcport_d      = srcport_q;
    ip_id_d        = ip_id_q;
    csum_d         = csum_q;
    tx_frames_d    = tx_frames_q;
    beat_cnt_d     = beat_cnt_q;
    tdata_d        = tdata_q;
    tkeep_d        = tkeep_q;
    tlast_d        = tlast_q;
    tvalid_d       = tvalid_q;
    fifo_cmd_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_cmd_empty && rst_n) begin
          fifo_cmd_rd_en = 1'b1;
          cmd_d          = fifo_cmd_dout;
          magic_d        = adapter_reg_magic;
          dstmac_d       = adapter_reg_dstmac;
          srcmac_d       = adapter_reg_srcmac;
          dstip_d        = adapter_reg_dstip;
          srcip_d        = adapter_reg_srcip;
          dstport_d      = adapter_reg_dstport;
          srcport_d      = adapter_reg_srcport;
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_CSUM;
      ST_CSUM: begin
        csum_d     = csum_w;
        beat_cnt_d = 3'd0;
        tdata_d    = beat_data;
        tkeep_d    = 8'hFF;
        tlast_d    = 1'b0;
        tvalid_d   = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          if (beat_cnt_q == 3'd7) begin
            state_d     = ST_IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            tdata_d     = 64'h0;
            tkeep_d     = 8'h00;
            ip_id_d     = ip_id_q + 16'd1;
            tx_frames_d = tx_frames_q + 32'd1;
          end else begin
            beat_cnt_d = beat_sel;
            tdata_d    = beat_data;
            tkeep_d    = (beat_sel == 3'd7) ? 8'h0F : 8'hFF;
            tlast_d    = (beat_sel == 3'd7);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      magic_q     <= 32'h0;
      dstmac_q    <= 48'h0;
      srcmac_q    <= 48'h0;
      dstip_q     <= 32'h0;
      srcip_q     <= 32'h0;
      dstport_q   <= 16'h0;
      srcport_q   <= 16'h0;
      ip_id_q     <= 16'h0;
      csum_q      <= 16'h0;
      tx_frames_q <= 32'h0;
      beat_cnt_q  <= 3'd0;
      tdata_q     <= 64'h0;
      tkeep_q     <= 8'h00;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      magic_q     <= magic_d;
      dstmac_q    <= dstmac_d;
      srcmac_q    <= srcmac_d;
      dstip_q     <= dstip_d;
      srcip_q     <= srcip_d;
      dstport_q   <= dstport_d;
      srcport_q   <= srcport_d;
      ip_id_q     <= ip_id_d;
      csum_q      <= csum_d;
      tx_frames_q <= tx_frames_d;
      beat_cnt_q  <= beat_cnt_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign tx_frames     = tx_frames_q;

endmodule

// File: tb/tb_nettlp_cmd_tx.sv
// Directed bench for nettlp_cmd_tx: beat table, frame model and multi-cycle corner sequences.
module tb_nettlp_cmd_tx;
  import nettlp_cmd_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fifo_cmd_rd_en;
  logic             fifo_cmd_empty = 1'b1;
  FIFO_NETTLP_CMD_T fifo_cmd_dout = '0;
  logic [31:0]      adapter_reg_magic, adapter_reg_dstip, adapter_reg_srcip;
  logic [47:0]      adapter_reg_dstmac, adapter_reg_srcmac;
  logic [15:0]      adapter_reg_dstport, adapter_reg_srcport;
  logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [63:0]      m_axis_tdata;
  logic [7:0]       m_axis_tkeep;
  logic [31:0]      tx_frames;

  nettlp_cmd_tx #(.ETH_W(64), .IP_TTL(8'd64)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_cmd_rd_en(fifo_cmd_rd_en), .fifo_cmd_empty(fifo_cmd_empty), .fifo_cmd_dout(fifo_cmd_dout),
    .adapter_reg_magic(adapter_reg_magic),
    .adapter_reg_dstmac(adapter_reg_dstmac), .adapter_reg_srcmac(adapter_reg_srcmac),
    .adapter_reg_dstip(adapter_reg_dstip), .adapter_reg_srcip(adapter_reg_srcip),
    .adapter_reg_dstport(adapter_reg_dstport), .adapter_reg_srcport(adapter_reg_srcport),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .tx_frames(tx_frames)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // First-word-fall-through FIFO model
  FIFO_NETTLP_CMD_T fq[$];
  always @(posedge clk) begin
    if (fifo_cmd_rd_en && fq.size() > 0) void'(fq.pop_front());
    fifo_cmd_empty <= (fq.size() == 0);
    fifo_cmd_dout  <= (fq.size() > 0) ? fq[0] : '0;
  end

  int pop_cyc = 0;
  int n_pops  = 0;
  always @(negedge clk) begin
    if (fifo_cmd_rd_en) begin
      pop_cyc = cyc;
      n_pops  = n_pops + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [479:0] got, input logic [479:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  function automatic logic [15:0] ip_csum(input logic [15:0] id, input logic [31:0] s, input logic [31:0] d);
    logic [31:0] acc;
    acc = 32'h4500 + 32'h002C + {16'h0, id} + 32'h4000 + 32'h4011;
    acc = acc + {16'h0, s[31:16]} + {16'h0, s[15:0]} + {16'h0, d[31:16]} + {16'h0, d[15:0]};
    while (acc[31:16] != 16'h0) acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    return ~acc[15:0];
  endfunction

  function automatic logic [479:0] model_frame(input FIFO_NETTLP_CMD_T c, input logic [15:0] id,
                                               input logic [31:0] s, input logic [31:0] d);
    return {adapter_reg_dstmac, adapter_reg_srcmac, 16'h0800,
            8'h45, 8'h00, 16'h002C, id, 16'h4000, 8'd64, 8'h11, ip_csum(id, s, d), s, d,
            adapter_reg_srcport, adapter_reg_dstport, 16'h0018, 16'h0000,
            adapter_reg_magic, c, 16'h0000};
  endfunction

  // Receives one frame starting at a negedge; optionally flips tready randomly and
  // retargets dstip once beat chg_beat has been accepted.
  task automatic recv_frame(input bit bp, input int chg_beat, input logic [31:0] chg_ip,
                            output logic [479:0] got, output logic [511:0] raw,
                            output logic [63:0] keeps, output logic [7:0] lasts,
                            output int t_first, output int t_last);
    int beats = 0;
    int budget = 0;
    bit stall = 0;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_last;
    got = '0; raw = '0; keeps = '0; lasts = '0; t_first = 0; t_last = 0;
    while (beats < 8 && budget < 400) begin
      if (stall) begin
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_tdata", m_axis_tdata, s_data);
        check("stall_tkeep", m_axis_tkeep, s_keep);
        check("stall_tlast", m_axis_tlast, s_last);
      end
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = 0;
      if (m_axis_tvalid) begin
        if (beats == 0 && t_first == 0) t_first = cyc;
        if (m_axis_tready) begin
          raw[64*beats +: 64] = m_axis_tdata;
          keeps[8*beats +: 8] = m_axis_tkeep;
          lasts[beats]        = m_axis_tlast;
          for (int k = 0; k < 8; k++)
            if (8*beats + k < 60) got[479-8*(8*beats+k) -: 8] = m_axis_tdata[8*k +: 8];
          if (m_axis_tlast) t_last = cyc;
          if (beats == chg_beat) adapter_reg_dstip = chg_ip;
          beats++;
        end else begin
          stall  = 1;
          s_data = m_axis_tdata;
          s_keep = m_axis_tkeep;
          s_last = m_axis_tlast;
        end
      end
      @(negedge clk);
      budget++;
    end
    m_axis_tready = 1'b1;
    if (beats < 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL recv_timeout: got %0d beats required 8", beats);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_vec_t;

  beat_vec_t tbl [8];

  localparam logic [31:0] IP_SRC  = 32'hC0A80A01;
  localparam logic [31:0] IP_DST  = 32'hC0A80A03;
  localparam logic [31:0] IP_DST2 = 32'hC0A80A63;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    FIFO_NETTLP_CMD_T cmd0, cmda, cmdb;
    FIFO_NETTLP_CMD_T cmds [3];
    logic [479:0] got, got0;
    logic [511:0] raw, raw0;
    logic [63:0]  keeps;
    logic [7:0]   lasts;
    logic [63:0]  mask;
    int tf, tl, prev_tl, pops0, wait_cnt;

    tbl[0] = '{64'h7766554433221100, 8'hFF, 1'b0};
    tbl[1] = '{64'h00450008BBAA9988, 8'hFF, 1'b0};
    tbl[2] = '{64'h1140004000002C00, 8'hFF, 1'b0};
    tbl[3] = '{64'hA8C0010AA8C06CA5, 8'hFF, 1'b0};
    tbl[4] = '{64'h180001300030030A, 8'hFF, 1'b0};
    tbl[5] = '{64'h0201FECAEFBE0000, 8'hFF, 1'b0};
    tbl[6] = '{64'h0A09080706050403, 8'hFF, 1'b0};
    tbl[7] = '{64'h0000000000000C0B, 8'h0F, 1'b1};

    cmd0    = 96'h0102030405060708090A0B0C;
    cmda    = 96'hA1A2A3A4A5A6A7A8A9AAABAC;
    cmdb    = 96'h5A5A5A5A_DEADBEEF_00FF00FF;
    cmds[0] = 96'h111111111111111111111111;
    cmds[1] = 96'h222222222222222222222222;
    cmds[2] = 96'h333333333333333333333333;

    rst_n               = 1'b0;
    m_axis_tready       = 1'b1;
    adapter_reg_magic   = 32'hBEEFCAFE;
    adapter_reg_dstmac  = 48'h001122334455;
    adapter_reg_srcmac  = 48'h66778899AABB;
    adapter_reg_srcip   = IP_SRC;
    adapter_reg_dstip   = IP_DST;
    adapter_reg_srcport = 16'h3000;
    adapter_reg_dstport = 16'h3001;

    // Reset state, with a record already waiting that must not be popped under reset
    fq.push_back(cmd0);
    repeat (4) @(negedge clk);
    check("rst_rd_en", fifo_cmd_rd_en, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 64'h0);
    check("rst_tkeep", m_axis_tkeep, 8'h00);
    check("rst_tx_frames", tx_frames, 32'h0);
    rst_n = 1'b1;

    // Single frame against the hand-computed beat table
    recv_frame(1'b0, -1, 32'h0, got0, raw0, keeps, lasts, tf, tl);
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 8; k++) mask[8*k +: 8] = tbl[b].keep[k] ? 8'hFF : 8'h00;
      check($sformatf("beat%0d_tdata", b), raw0[64*b +: 64] & mask, tbl[b].data);
      check($sformatf("beat%0d_tkeep", b), keeps[8*b +: 8], tbl[b].keep);
      check($sformatf("beat%0d_tlast", b), lasts[b], tbl[b].last);
    end
    check("single_csum", got0[479-8*24 -: 16], 16'hA56C);
    check("single_frame", got0, model_frame(cmd0, 16'h0000, IP_SRC, IP_DST));
    check("lat_beat0", tf - pop_cyc, 3);
    check("lat_tlast", tl - pop_cyc, 10);
    check("single_tx_frames", tx_frames, 32'd1);
    check("single_pops", n_pops, 1);

    // Three queued records: back-to-back with an incrementing id
    do_reset();
    pops0 = n_pops;
    for (int f = 0; f < 3; f++) fq.push_back(cmds[f]);
    prev_tl = 0;
    for (int f = 0; f < 3; f++) begin
      recv_frame(1'b0, -1, 32'h0, got, raw, keeps, lasts, tf, tl);
      check($sformatf("seq%0d_id", f), got[479-8*18 -: 16], 16'(f));
      check($sformatf("seq%0d_frame", f), got, model_frame(cmds[f], 16'(f), IP_SRC, IP_DST));
      if (f > 0) check($sformatf("seq%0d_gap", f), tf - prev_tl, 4);
      prev_tl = tl;
    end
    check("seq_tx_frames", tx_frames, 32'd3);
    check("seq_pops", n_pops - pops0, 3);

    // Random backpressure must give the same byte stream
    do_reset();
    fq.push_back(cmd0);
    recv_frame(1'b1, -1, 32'h0, got, raw, keeps, lasts, tf, tl);
    check("bp_frame", got, got0);
    check("bp_beat7", raw[511:448] & 64'h00000000FFFFFFFF, raw0[511:448] & 64'h00000000FFFFFFFF);

    // dstip changes while beat 3 is on the bus
    do_reset();
    fq.push_back(cmda);
    fq.push_back(cmdb);
    recv_frame(1'b0, 3, IP_DST2, got, raw, keeps, lasts, tf, tl);
    check("chg_cur_csum", got[479-8*24 -: 16], 16'hA56C);
    check("chg_cur_frame", got, model_frame(cmda, 16'h0000, IP_SRC, IP_DST));
    recv_frame(1'b0, -1, 32'h0, got, raw, keeps, lasts, tf, tl);
    check("chg_next_csum", got[479-8*24 -: 16], 16'hA50B);
    check("chg_next_frame", got, model_frame(cmdb, 16'h0001, IP_SRC, IP_DST2));
    adapter_reg_dstip = IP_DST;

    // Reset while beat 4 is presented
    fq.push_back(cmda);
    wait_cnt = 0;
    while (!m_axis_tvalid && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("mid_rst_started", m_axis_tvalid, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    @(negedge clk);
    check("mid_rst_tx_frames", tx_frames, 32'h0);
    rst_n = 1'b1;
    fq.push_back(cmdb);
    recv_frame(1'b0, -1, 32'h0, got, raw, keeps, lasts, tf, tl);
    check("mid_rst_id", got[479-8*18 -: 16], 16'h0000);
    check("mid_rst_frame", got, model_frame(cmdb, 16'h0000, IP_SRC, IP_DST));
    check("mid_rst_tx_after", tx_frames, 32'd1);

    // ip_id wrap from 0xFFFF
    @(negedge clk);
    force dut.ip_id_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.ip_id_q;
    @(negedge clk);
    fq.push_back(cmda);
    fq.push_back(cmdb);
    recv_frame(1'b0, -1, 32'h0, got, raw, keeps, lasts, tf, tl);
    check("wrap_id_ffff", got[479-8*18 -: 16], 16'hFFFF);
    check("wrap_frame_ffff", got, model_frame(cmda, 16'hFFFF, IP_SRC, IP_DST));
    recv_frame(1'b0, -1, 32'h0, got, raw, keeps, lasts, tf, tl);
    check("wrap_id_0000", got[479-8*18 -: 16], 16'h0000);
    check("wrap_frame_0000", got, model_frame(cmdb, 16'h0000, IP_SRC, IP_DST));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
